// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter and the cache controllers.
// Lane 0 carries the most significant byte of a word.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    localparam int LANES = 4;

    typedef logic [LANES-1:0][7:0] lanes_t;

    function automatic lanes_t pack_lanes(input logic [31:0] word);
        lanes_t l;
        for (int i = 0; i < LANES; i++) begin
            l[i] = word[31-8*i -: 8];
        end
        return l;
    endfunction

    function automatic logic [31:0] unpack_lanes(input lanes_t l);
        logic [31:0] w;
        for (int i = 0; i < LANES; i++) begin
            w[31-8*i -: 8] = l[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for both cache ports plus the memory-side lanes.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              done0;
    logic              done1;
    logic              grant0;
    logic              grant1;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    lanes_t            mem_wdata;
    lanes_t            mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
        input  wdata0, wdata1, mem_rdata,
        output rdata0, rdata1, done0, done1,
        output grant0, grant1, busy,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
        output wdata0, wdata1, mem_rdata,
        input  rdata0, rdata1, done0, done1,
        input  grant0, grant1, busy,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker; on a tie the port not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_served,
    output logic o_valid,
    output logic o_winner
);

    logic w_tie;

    assign w_tie    = i_req0 & i_req1;
    assign o_valid  = i_req0 | i_req1;
    assign o_winner = w_tie  ? ~i_last_served :
                      i_req1 ? PORT_DATA : PORT_IFETCH;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the I-cache (port 0)
// and the D-cache (port 1), one word transaction at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic              r_port;
    logic              r_we;

    logic              w_valid;
    logic              w_win;
    logic              w_grant;
    logic              w_finish;
    logic              w_we;
    logic [ADDR_W-3:0] w_addr_hi;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rword;

    rr_pick2 u_pick (
        .i_req0        (bus.req0),
        .i_req1        (bus.req1),
        .i_last_served (r_last),
        .o_valid       (w_valid),
        .o_winner      (w_win)
    );

    assign w_we      = (w_win == PORT_DATA) ? bus.we1 : bus.we0;
    assign w_addr_hi = (w_win == PORT_DATA) ? bus.addr1[ADDR_W-1:2]
                                            : bus.addr0[ADDR_W-1:2];
    assign w_wdata   = (w_win == PORT_DATA) ? bus.wdata1 : bus.wdata0;
    assign w_rword   = unpack_lanes(bus.mem_rdata);
    assign bus.busy  = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_last        <= PORT_DATA;
            r_port        <= PORT_IFETCH;
            r_we          <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.grant0    <= 1'b0;
            bus.grant1    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cnt         <= '0;
                r_last        <= w_win;
                r_port        <= w_win;
                r_we          <= w_we;
                bus.mem_addr  <= {w_addr_hi, 2'b00};
                bus.mem_we    <= w_we;
                bus.mem_wdata <= pack_lanes(w_wdata);
                bus.grant0    <= (w_win == PORT_IFETCH);
                bus.grant1    <= (w_win == PORT_DATA);
            end
            if (r_state == ACCESS) begin
                r_cnt      <= r_cnt + 1'b1;
                bus.mem_we <= 1'b0;
            end
            // Writes leave the requester's rdata untouched.
            if (w_finish) begin
                if (!r_we && r_port == PORT_DATA) begin
                    bus.rdata1 <= w_rword;
                end
                if (!r_we && r_port == PORT_IFETCH) begin
                    bus.rdata0 <= w_rword;
                end
                bus.done0 <= (r_port == PORT_IFETCH);
                bus.done1 <= (r_port == PORT_DATA);
            end
            if (r_state == RESP) begin
                bus.done0  <= 1'b0;
                bus.done1  <= 1'b0;
                bus.grant0 <= 1'b0;
                bus.grant1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int L = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   armed  = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: a transaction is granted at edge m_g and completes L edges later.
    bit          m_busy;
    bit          m_last;
    bit          m_port;
    bit          m_we;
    int          m_g;
    logic [31:0] e_rdata [2];
    bit          e_done  [2];
    bit          e_grant [2];
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    bit          e_mwe;

    int dport[$];
    int dcyc[$];

    function automatic logic [31:0] lanes_word(input lanes_t l);
        return {l[0], l[1], l[2], l[3]};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            armed   = 1'b1;
            m_busy  = 1'b0;
            m_last  = 1'b1;
            e_rdata = '{32'h0, 32'h0};
            e_done  = '{1'b0, 1'b0};
            e_grant = '{1'b0, 1'b0};
            e_maddr = 32'h0;
            e_mwd   = 32'h0;
            e_mwe   = 1'b0;
        end else begin
            e_mwe  = 1'b0;
            e_done = '{1'b0, 1'b0};
            if (m_busy) begin
                if (cyc - m_g == L) begin
                    e_done[m_port] = 1'b1;
                    if (!m_we) e_rdata[m_port] = lanes_word(bus.mem_rdata);
                end else if (cyc - m_g == L + 1) begin
                    e_grant = '{1'b0, 1'b0};
                    m_busy  = 1'b0;
                end
            end else if (bus.req0 || bus.req1) begin
                m_port  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                m_last  = m_port;
                m_busy  = 1'b1;
                m_g     = cyc;
                m_we    = m_port ? bus.we1 : bus.we0;
                e_maddr = (m_port ? bus.addr1 : bus.addr0) & 32'hFFFF_FFFC;
                e_mwd   = m_port ? bus.wdata1 : bus.wdata0;
                e_mwe   = m_we;
                e_grant[m_port] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("rdata0", bus.rdata0, e_rdata[0]);
            chk("rdata1", bus.rdata1, e_rdata[1]);
            chk("done0", 32'(bus.done0), 32'(e_done[0]));
            chk("done1", 32'(bus.done1), 32'(e_done[1]));
            chk("grant0", 32'(bus.grant0), 32'(e_grant[0]));
            chk("grant1", 32'(bus.grant1), 32'(e_grant[1]));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("mem_addr", bus.mem_addr, e_maddr);
            chk("mem_we", 32'(bus.mem_we), 32'(e_mwe));
            chk("mem_wdata", lanes_word(bus.mem_wdata), e_mwd);
            chk("done_excl", 32'(bus.done0 & bus.done1), 32'h0);
        end
    end

    task automatic set_q(input int p, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic rnd_q(input int p);
        set_q(p, 1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom());
    endtask

    task automatic wait_grant(input int p, input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.grant0 : bus.grant1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'h1);
    endtask

    task automatic wait_done(input int p, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.done0 : bus.done1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'h1);
    endtask

    task automatic drive_port(input int p);
        bit r;
        bit own;
        r   = (p == 0) ? bus.req0 : bus.req1;
        own = m_busy && (int'(m_port) == p);
        if (r && e_done[p]) begin
            if ($urandom_range(0, 1) == 0) set_q(p, 1'b0, 1'b0, 32'h0, 32'h0);
            else rnd_q(p);
        end else if (r && own) begin
            // Post-grant qualifier churn must not reach memory.
            if ($urandom_range(0, 2) == 0) rnd_q(p);
        end else if (!r && $urandom_range(0, 3) == 0) begin
            rnd_q(p);
        end
    endtask

    initial begin
        bit ok;
        int nwe;
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_q(1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rdata0", bus.rdata0, 32'h0);
        chk("rst_rdata1", bus.rdata1, 32'h0);
        chk("rst_mwe", 32'(bus.mem_we), 32'h0);
        chk("rst_grant0", 32'(bus.grant0), 32'h0);
        reset = 1'b0;

        // Single read from port 0.
        bus.mem_rdata[0] = 8'hDE; bus.mem_rdata[1] = 8'hAD;
        bus.mem_rdata[2] = 8'hBE; bus.mem_rdata[3] = 8'hEF;
        set_q(0, 1'b1, 1'b0, 32'h0000_1A37, 32'h0);
        wait_grant(0, "rd_grant", ok);
        if (ok) begin
            for (int k = 0; k < L; k++) begin
                chk("rd_addr", bus.mem_addr, 32'h0000_1A34);
                chk("rd_we", 32'(bus.mem_we), 32'h0);
                chk("rd_early", 32'(bus.done0), 32'h0);
                @(negedge clk);
            end
            chk("rd_done", 32'(bus.done0), 32'h1);
            chk("rd_data", bus.rdata0, 32'hDEAD_BEEF);
            chk("rd_other", bus.rdata1, 32'h0);
        end
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Single write from port 1.
        set_q(1, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678);
        wait_grant(1, "wr_grant", ok);
        if (ok) begin
            nwe = 0;
            chk("wr_lanes", lanes_word(bus.mem_wdata), 32'h1234_5678);
            chk("wr_lane0", 32'(bus.mem_wdata[0]), 32'h12);
            chk("wr_addr", bus.mem_addr, 32'h0000_2000);
            for (int k = 0; k < L; k++) begin
                if (bus.mem_we) nwe++;
                @(negedge clk);
            end
            chk("wr_we_cycles", nwe, 1);
            chk("wr_done", 32'(bus.done1), 32'h1);
            chk("wr_rdata1", bus.rdata1, 32'h0);
        end
        set_q(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Simultaneous held requests right after reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_q(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        set_q(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        for (int i = 0; i < 40 && dport.size() < 4; i++) begin
            @(negedge clk);
            if (bus.done0) begin dport.push_back(0); dcyc.push_back(cyc); end
            if (bus.done1) begin dport.push_back(1); dcyc.push_back(cyc); end
        end
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_q(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("sim_count", dport.size(), 4);
        for (int i = 0; i < dport.size(); i++) begin
            chk("sim_order", dport[i], i % 2);
            if (i > 0) chk("sim_gap", dcyc[i] - dcyc[i-1], L + 2);
        end
        repeat (3) @(negedge clk);

        // Port 1 arrives during port 0's access and must win next.
        set_q(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        wait_grant(0, "stv_grant0", ok);
        set_q(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        wait_done(0, "stv_done0");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.grant0 || bus.grant1) break;
        end
        chk("stv_g1", 32'(bus.grant1), 32'h1);
        chk("stv_g0", 32'(bus.grant0), 32'h0);
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done(1, "stv_done1");
        set_q(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a read.
        set_q(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
        wait_grant(0, "mid_grant", ok);
        repeat (2) begin
            @(negedge clk);
            chk("mid_nodone", 32'(bus.done0), 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy", 32'(bus.busy), 32'h0);
        chk("mid_grant", 32'(bus.grant0), 32'h0);
        chk("mid_done", 32'(bus.done0), 32'h0);
        chk("mid_maddr", bus.mem_addr, 32'h0);
        chk("mid_rdata0", bus.rdata0, 32'h0);
        wait_grant(0, "mid_regrant", ok);
        if (ok) begin
            for (int k = 0; k < L; k++) begin
                chk("mid_early", 32'(bus.done0), 32'h0);
                @(negedge clk);
            end
            chk("mid_redone", 32'(bus.done0), 32'h1);
            chk("mid_redata", bus.rdata0, 32'hDEAD_BEEF);
        end
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Address change after grant is ignored.
        set_q(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        wait_grant(0, "lat_grant", ok);
        set_q(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        if (ok) begin
            for (int k = 0; k <= L; k++) begin
                chk("lat_addr", bus.mem_addr, 32'h0000_0100);
                if (k < L) @(negedge clk);
            end
        end
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.mem_rdata = $urandom();
            reset = ($urandom_range(0, 79) == 0);
            drive_port(0);
            drive_port(1);
        end
        @(negedge clk);
        reset = 1'b0;
        set_q(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_q(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, fixed-latency, byte-lane main memory between two cache controllers: port 0 is the instruction cache and port 1 is the data cache.
- Accepts one word-sized read or write transaction at a time.
- Drives the memory address, write enable and byte lanes, waits the fixed memory latency, then returns read data and a one-cycle done pulse to the winning requester.
- Arbitration is round-robin, so neither cache can starve the other.

Parameters:
- ADDR_W, 32, width of byte address.
- DATA_W, 32, word width; always 4 byte lanes.
- MEM_LATENCY, 4, cycles from the issue edge to valid memory read data; must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  transaction request from port 0 / port 1. Held high, with its qualifiers stable, until that port's done pulse.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address; bits [1:0] are ignored and driven as 0 to memory.
- wdata0 / wdata1  in  DATA_W  write word; bits [31:24] map to byte lane 0.
- rdata0 / rdata1  out  DATA_W  read word, registered.
- done0 / done1  out  1  one-cycle completion pulse.
- grant0 / grant1  out  1  high from the grant edge through the done cycle inclusive.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  address to memory, held for the whole transaction.
- mem_we  out  1  memory write enable, high for exactly one cycle.
- mem_wdata  out  4x8  byte lanes to memory; lane0 = word[31:24] … lane3 = word[7:0].
- mem_rdata  in  4x8  byte lanes from memory, same lane order.

Behaviour:
- Reset (synchronous, priority over everything):
  - state = IDLE; all outputs 0, including rdata0/1 and mem lanes.
  - last_served = 1, so port 0 wins the first tie.
  - Reset asserted mid-transaction aborts it: no done pulse, and mem_we drops on the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If only one req is high, grant that port.
  - If both are high, grant the port != last_served.
  - On the grant edge: latch we/addr/wdata of the winner into internal registers; drive mem_addr = {addr[31:2], 2'b00}, mem_wdata = latched wdata, mem_we = latched we; cnt = 0; last_served = winner; go to ACCESS.
  - With no req, stay in IDLE with all outputs quiet.
- ACCESS:
  - mem_we is cleared on the first edge after the grant edge.
  - cnt increments on each edge.
  - On the edge where cnt == MEM_LATENCY-1:
    - If the transaction is a read, rdataN <= {lane0, lane1, lane2, lane3}.
    - If it is a write, rdataN holds its old value.
    - doneN <= 1; go to RESP.
- Latency: done is high in the cycle beginning MEM_LATENCY edges after the grant edge.
- RESP: doneN <= 0, grantN <= 0; go to IDLE. mem_addr holds until the next grant.
- Back-to-back:
  - Requests are re-sampled only in IDLE, so the minimum spacing between grants is MEM_LATENCY+2 cycles.
  - A requester that keeps req high after its done starts a new transaction, but if the other port is also requesting, the other port wins.
- Requests arriving during ACCESS/RESP are ignored until IDLE; nothing is queued.
- rdata of the non-granted port never changes.
- done0 and done1 are never high in the same cycle.
- Changes to addr/we/wdata after the grant edge have no effect (latched).
- MEM_LATENCY == 1: ACCESS lasts a single cycle, and mem_we is high during it.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - port index constants (PORT_IFETCH=0, PORT_DATA=1);
  - the lane-packing convention (lane0 = MSB byte) as pack/unpack functions shared with the cache controllers.
- One sub-module, rr_pick2: combinational 2-way round-robin picker (inputs req0, req1, last_served; outputs a valid flag and the winner index). It is instantiated once.

Test Plan:
- Single read, MEM_LATENCY=4: req0=1, we0=0, addr0=0x0000_1A37 → mem_addr=0x0000_1A34 and mem_we=0 throughout; memory returns lanes {DE,AD,BE,EF}; done0 high exactly 4 cycles after the grant edge; rdata0=0xDEADBEEF; rdata1 unchanged.
- Single write: req1=1, we1=1, addr1=0x2000, wdata1=0x12345678 → mem_we high for exactly one cycle with lanes {12,34,56,78}; done1 pulses after 4 cycles; rdata1 unchanged.
- Simultaneous requests:
  - After reset, req0=req1=1 with both held → grants go in order 0, 1, 0, 1.
  - done pulses are spaced MEM_LATENCY+2=6 cycles apart and never overlap.
- Starvation check: hold req0 permanently, then raise req1 during port 0's ACCESS → port 1 receives the very next grant.
- Reset mid-ACCESS: assert reset at cnt=2 of a read → no done0; all outputs 0 on the next edge; the next request after reset is granted normally with full latency.
- Qualifier change after grant: change addr0 from 0x100 to 0x200 one cycle after the grant → mem_addr stays 0x100 for the whole transaction.
